// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and requester IDs.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/mem_watchdog.sv
// Watchdog for an outstanding memory access: counts BUSY cycles, flags the last allowed one.
// Latency: expired is combinational from the count, high in the TIMEOUT-th enabled cycle.
// Backpressure: none; the counter saturates at TIMEOUT instead of wrapping.
//
// Ports: clk, rstn (async active-low), clr (zero the count), en (count this cycle),
//        expired (this enabled cycle is the TIMEOUT-th one since clr).
module mem_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // The count reaches TIMEOUT at the end of this cycle, so this is the
    // final BUSY cycle that m_ack is allowed to arrive in.
    assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction and a data requester.
// Latency: gnt and m_req one cycle after the sampling edge; rvalid/err one cycle after m_ack/timeout.
// Backpressure: requests are only sampled in IDLE; a requester holds req until it sees its gnt.
//
// Ports: clk, rstn (async active-low);
//        if_*  instruction requester (read only);
//        d_*   data requester (read/write with byte strobes);
//        m_*   memory side, m_req held with a stable command until m_ack or watchdog expiry.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rstn,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,

    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_ack,
    input  logic [DATA_W-1:0]   m_rdata
);

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic                win;

    logic                cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [DATA_W/8-1:0] cmd_wstrb_q, cmd_wstrb_d;

    logic                if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
    logic                if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic                if_err_q, if_err_d, d_err_q, d_err_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;

    logic                wd_clr, wd_en, wd_expired;

    assign wd_en = (state_q == BUSY);

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            owner_q     <= REQ_IF;
            last_q      <= REQ_IF;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_wstrb_q <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_err_q    <= 1'b0;
            d_err_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_wstrb_q <= cmd_wstrb_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_err_q    <= if_err_d;
            d_err_q     <= d_err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_wstrb_d = cmd_wstrb_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_err_d    = 1'b0;
        d_err_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        wd_clr      = 1'b0;

        // A tie goes to whichever side did not win the previous grant.
        if (if_req && d_req) begin
            win = (last_q == REQ_IF) ? REQ_D : REQ_IF;
        end else begin
            win = d_req ? REQ_D : REQ_IF;
        end

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d = BUSY;
                    owner_d = win;
                    last_d  = win;
                    wd_clr  = 1'b1;
                    if (win == REQ_D) begin
                        d_gnt_d     = 1'b1;
                        cmd_we_d    = d_we;
                        cmd_addr_d  = d_addr;
                        cmd_wdata_d = d_wdata;
                        cmd_wstrb_d = d_wstrb;
                    end else begin
                        if_gnt_d    = 1'b1;
                        cmd_we_d    = 1'b0;
                        cmd_addr_d  = if_addr;
                        cmd_wdata_d = '0;
                        cmd_wstrb_d = '0;
                    end
                end
            end
            BUSY: begin
                // An ack arriving in the expiry cycle still completes normally.
                if (m_ack) begin
                    state_d = RESP;
                    if (owner_q == REQ_D) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = m_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = m_rdata;
                    end
                end else if (wd_expired) begin
                    state_d = RESP;
                    if (owner_q == REQ_D) begin
                        d_err_d = 1'b1;
                    end else begin
                        if_err_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The memory command is only visible while the access is outstanding.
    assign m_req   = (state_q == BUSY);
    assign m_we    = m_req & cmd_we_q;
    assign m_addr  = m_req ? cmd_addr_q  : '0;
    assign m_wdata = m_req ? cmd_wdata_q : '0;
    assign m_wstrb = m_req ? cmd_wstrb_q : '0;

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_err    = if_err_q;
    assign d_err     = d_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
